// File: rtl/axis_trailer_strip.sv
// Strips the pad/zero trailer from a framed AXI-Stream and applies the final tkeep.
// Define TRAILER_CHECK_EN to enable the malformed-trailer check on err_trailer.
module axis_trailer_strip #(
  parameter int CNT_W = 16
) (
  input  logic             tx_clk_out,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             m_axis_tvalid,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             pkt_done,
  output logic             pkt_drop,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err_trailer
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      h0_data_q, h0_data_d;
  logic [7:0]       h0_keep_q, h0_keep_d;
  logic [63:0]      h1_data_q, h1_data_d;
  logic [7:0]       h1_keep_q, h1_keep_d;
  logic             mv_q, mv_d;
  logic [63:0]      md_q, md_d;
  logic [7:0]       mk_q, mk_d;
  logic             ml_q, ml_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic [7:0]       tk_eff;
  logic [63:0]      masked;

  assign s_axis_tready = !mv_q || m_axis_tready;
  assign acc = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = mv_q;
  assign m_axis_tdata  = md_q;
  assign m_axis_tkeep  = mk_q;
  assign m_axis_tlast  = ml_q;
  assign pkt_done      = done_q;
  assign pkt_drop      = drop_q;
  assign pkt_cnt       = cnt_q;

  // A pad byte of zero means the final beat is full.
  always_comb begin
    tk_eff = (h1_data_q[7:0] == 8'h00) ? 8'hFF : h1_data_q[7:0];
    masked = '0;
    for (int i = 0; i < 8; i++) begin
      masked[8*i +: 8] = tk_eff[i] ? h0_data_q[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    h0_data_d = h0_data_q;
    h0_keep_d = h0_keep_q;
    h1_data_d = h1_data_q;
    h1_keep_d = h1_keep_q;
    mv_d      = mv_q;
    md_d      = md_q;
    mk_d      = mk_q;
    ml_d      = ml_q;
    done_d    = mv_q && m_axis_tready && ml_q;
    drop_d    = 1'b0;
    cnt_d     = cnt_q + CNT_W'(done_d);
    if (mv_q && m_axis_tready) mv_d = 1'b0;
    if (acc) begin
      unique case (1'b1)
        (!s_axis_tlast && state_q == S_EMPTY): begin
          h0_data_d = s_axis_tdata;
          h0_keep_d = s_axis_tkeep;
          state_d   = S_ONE;
        end
        (!s_axis_tlast && state_q == S_ONE): begin
          h1_data_d = s_axis_tdata;
          h1_keep_d = s_axis_tkeep;
          state_d   = S_TWO;
        end
        (!s_axis_tlast && state_q == S_TWO): begin
          mv_d      = 1'b1;
          md_d      = h0_data_q;
          mk_d      = h0_keep_q;
          ml_d      = 1'b0;
          h0_data_d = h1_data_q;
          h0_keep_d = h1_keep_q;
          h1_data_d = s_axis_tdata;
          h1_keep_d = s_axis_tkeep;
        end
        (s_axis_tlast && state_q == S_TWO): begin
          mv_d    = 1'b1;
          md_d    = masked;
          mk_d    = tk_eff;
          ml_d    = 1'b1;
          state_d = S_EMPTY;
        end
        default: begin
          drop_d  = 1'b1;
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge tx_clk_out) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      h0_data_q <= '0;
      h0_keep_q <= '0;
      h1_data_q <= '0;
      h1_keep_q <= '0;
      mv_q      <= 1'b0;
      md_q      <= '0;
      mk_q      <= '0;
      ml_q      <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h0_data_q <= h0_data_d;
      h0_keep_q <= h0_keep_d;
      h1_data_q <= h1_data_d;
      h1_keep_q <= h1_keep_d;
      mv_q      <= mv_d;
      md_q      <= md_d;
      mk_q      <= mk_d;
      ml_q      <= ml_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TRAILER_CHECK_EN
  logic err_q, err_d;
  logic pad_ok;

  always_comb begin
    pad_ok = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      if (h1_data_q[7:0] == 8'((1 << m) - 1)) pad_ok = 1'b1;
    end
    err_d = acc && s_axis_tlast && (state_q == S_TWO) &&
            ((h1_data_q[63:8] != '0) || (s_axis_tdata != '0) || !pad_ok);
  end

  always_ff @(posedge tx_clk_out) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_trailer = err_q;
`else
  assign err_trailer = 1'b0;
`endif

endmodule

// File: tb/tb_axis_trailer_strip.sv
// Bench for axis_trailer_strip: directed and random packets against a packet-level model.
// Honours TRAILER_CHECK_EN for the err_trailer expectations.
module tb_axis_trailer_strip;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tready;
  logic        pkt_done;
  logic        pkt_drop;
  logic [15:0] pkt_cnt;
  logic        err_trailer;

  always #5 clk = ~clk;

  axis_trailer_strip #(.CNT_W(16)) dut (
    .tx_clk_out    (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .pkt_done      (pkt_done),
    .pkt_drop      (pkt_drop),
    .pkt_cnt       (pkt_cnt),
    .err_trailer   (err_trailer)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t act_q[$];
  beat_t cur[$];

  int checks = 0;
  int failures = 0;
  int stall_n = 0;
  int rdy_pct = 100;
  logic [15:0] mcnt = '0;
  bit exp_drop_nx = 0;
  bit exp_err_nx = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pad_ok(input logic [7:0] p);
    for (int m = 1; m <= 8; m++) if (p == 8'((1 << m) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  // Packet-level reference: everything is decided once the tlast beat is seen.
  task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    logic [63:0] pad, dd;
    logic [7:0] kk;
    cur.push_back('{d, k, l});
    if (!l) return;
    n = cur.size();
    if (n < 3) begin
      exp_drop_nx = 1'b1;
    end else begin
      for (int j = 0; j < n - 3; j++) exp_q.push_back('{cur[j].d, cur[j].k, 1'b0});
      pad = cur[n-2].d;
      kk = (pad[7:0] == 8'h00) ? 8'hFF : pad[7:0];
      dd = '0;
      for (int b = 0; b < 8; b++) if (kk[b]) dd[8*b +: 8] = cur[n-3].d[8*b +: 8];
      exp_q.push_back('{dd, kk, 1'b1});
`ifdef TRAILER_CHECK_EN
      exp_err_nx = (pad[63:8] != '0) || (cur[n-1].d != '0) || !pad_ok(pad[7:0]);
`endif
    end
    cur.delete();
  endtask

  task automatic cycle(input bit v, input logic [63:0] d, input logic [7:0] k,
                       input bit l, output bit acc);
    bit mhs, stall, exp_done;
    logic [73:0] held;
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    if (stall_n > 0) begin
      m_tready = 1'b0;
      stall_n--;
    end else begin
      m_tready = ($urandom_range(99) < rdy_pct);
    end
    @(negedge clk);
    chk("s_tready_rule", 80'(s_tready), 80'(!m_tvalid || m_tready));
    acc = v && s_tready;
    mhs = m_tvalid && m_tready;
    stall = m_tvalid && !m_tready;
    held = {m_tvalid, m_tlast, m_tkeep, m_tdata};
    exp_done = mhs && m_tlast;
    if (mhs) act_q.push_back('{m_tdata, m_tkeep, m_tlast});
    if (acc) model_accept(d, k, l);
    @(posedge clk);
    #1;
    if (exp_done) mcnt++;
    chk("pkt_done", 80'(pkt_done), 80'(exp_done));
    chk("pkt_drop", 80'(pkt_drop), 80'(exp_drop_nx));
    chk("err_trailer", 80'(err_trailer), 80'(exp_err_nx));
    chk("pkt_cnt", 80'(pkt_cnt), 80'(mcnt));
    if (stall) chk("stall_stable", 80'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 80'(held));
    exp_drop_nx = 1'b0;
    exp_err_nx = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l,
                           input int gap);
    bit a;
    int t = 0;
    repeat ($urandom_range(gap)) cycle(1'b0, '0, '0, 1'b0, a);
    do begin
      cycle(1'b1, d, k, l, a);
      t++;
    end while (!a && t < 200);
    if (!a) chk("accept_timeout", 80'(a), 80'(1));
  endtask

  task automatic send_pkt(input int ndata, input logic [63:0] pad, input int gap,
                          input bit rnd_keep);
    logic [63:0] d;
    logic [7:0] k;
    for (int i = 0; i < ndata; i++) begin
      d = {$urandom, $urandom};
      k = rnd_keep ? 8'($urandom) : 8'hFF;
      send_beat(d, k, 1'b0, gap);
    end
    send_beat(pad, 8'hFF, 1'b0, gap);
    send_beat(64'd0, 8'hFF, 1'b1, gap);
  endtask

  task automatic drain_and_compare(input string tag);
    bit a;
    int t = 0;
    int n;
    rdy_pct = 100;
    while ((act_q.size() < exp_q.size() || m_tvalid) && t < 100) begin
      cycle(1'b0, '0, '0, 1'b0, a);
      t++;
    end
    repeat (2) cycle(1'b0, '0, '0, 1'b0, a);
    chk({tag, "_nbeats"}, 80'(act_q.size()), 80'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_beat"}, {act_q[i].l, act_q[i].k, act_q[i].d},
          {exp_q[i].l, exp_q[i].k, exp_q[i].d});
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    logic [15:0] cnt0;
    bit a;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 80'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 80'(0));
    chk("rst_pulses", 80'({pkt_done, pkt_drop, err_trailer}), 80'(0));
    chk("rst_cnt", 80'(pkt_cnt), 80'(0));
    chk("rst_tready", 80'(s_tready), 80'(1));
    rst_n = 1'b1;

    // Three data beats, final tkeep 07
    rdy_pct = 100;
    send_pkt(3, 64'h07, 0, 1'b0);
    drain_and_compare("p3");
    chk("p3_lastkeep", 80'(act_q.size() > 2 ? act_q[2].k : 8'hxx), 80'(8'h07));
    chk("p3_lastmask", 80'(act_q.size() > 2 ? act_q[2].d[63:24] : 40'hx), 80'(0));
    chk("p3_tlasts", 80'(act_q.size() > 2 ? {act_q[0].l, act_q[1].l, act_q[2].l} : 3'bx),
        80'(3'b001));
    chk("p3_cnt", 80'(pkt_cnt), 80'(1));
    clear_q();

    // Zero pad means full final beat
    send_pkt(2, 64'h00, 0, 1'b0);
    drain_and_compare("pad0");
    chk("pad0_keep", 80'(act_q.size() > 1 ? act_q[1].k : 8'hxx), 80'(8'hFF));
    clear_q();

    // Runt: pad plus tlast only
    cnt0 = pkt_cnt;
    send_pkt(0, 64'h03, 0, 1'b0);
    drain_and_compare("runt");
    chk("runt_cnt", 80'(pkt_cnt), 80'(cnt0));
    clear_q();

    // Five-cycle output stall mid-packet
    send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 0);
    send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 0);
    send_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0, 0);
    stall_n = 5;
    send_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b0, 0);
    send_beat(64'h0F, 8'hFF, 1'b0, 0);
    send_beat(64'h0, 8'hFF, 1'b1, 0);
    drain_and_compare("stall");
    clear_q();

    // Back-to-back four-beat packets
    cnt0 = pkt_cnt;
    send_pkt(2, 64'h3F, 0, 1'b0);
    send_pkt(2, 64'h01, 0, 1'b0);
    drain_and_compare("b2b");
    chk("b2b_cnt", 80'(pkt_cnt), 80'(cnt0 + 16'd2));
    clear_q();

    // Malformed pad: stray bit above the keep byte
    send_pkt(2, 64'h0100_0000_0000_0003, 0, 1'b0);
    drain_and_compare("badpad");
    chk("badpad_keep", 80'(act_q.size() > 1 ? act_q[1].k : 8'hxx), 80'(8'h03));
    clear_q();

    // Reset while a packet is in flight
    send_beat(64'hA1, 8'hFF, 1'b0, 0);
    send_beat(64'hA2, 8'hFF, 1'b0, 0);
    send_beat(64'hA3, 8'hFF, 1'b0, 0);
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_outs", 80'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 80'(0));
    chk("mid_rst_drop", 80'(pkt_drop), 80'(0));
    chk("mid_rst_tready", 80'(s_tready), 80'(1));
    rst_n = 1'b1;
    cur.delete();
    clear_q();
    mcnt = '0;
    send_pkt(3, 64'h1F, 0, 1'b0);
    drain_and_compare("post_rst");
    chk("post_rst_cnt", 80'(pkt_cnt), 80'(1));
    clear_q();

    // Random traffic with gaps and backpressure
    for (int p = 0; p < 40; p++) begin
      int nd;
      logic [63:0] pad;
      nd = $urandom_range(5);
      if ($urandom_range(3) == 0) pad = {$urandom, $urandom};
      else pad = 64'(8'((1 << $urandom_range(8)) - 1));
      rdy_pct = 60;
      send_pkt(nd, pad, 2, 1'b1);
    end
    drain_and_compare("rand");
    clear_q();
    cycle(1'b0, '0, '0, 1'b0, a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
